// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status-flag controller for a 16-entry FIFO with external storage.
// Define FIFO_PTR_CTRL_ERR_EN to add the sticky overflow/underflow error flags.
module fifo_ptr_ctrl #(
   parameter int AFULL_LVL  = 14,
   parameter int AEMPTY_LVL = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   output logic       wr_ok,
   output logic       rd_ok,
   output logic [3:0] wr_ptr,
   output logic [3:0] rd_ptr,
   output logic [4:0] count,
   output logic       full,
   output logic       empty,
   output logic       almost_full,
   output logic       almost_empty
`ifdef FIFO_PTR_CTRL_ERR_EN
   ,
   output logic       overflow,
   output logic       underflow
`endif
);

   localparam logic [4:0] DEPTH_CNT  = 5'd16;
   localparam logic [4:0] AFULL_CNT  = 5'(AFULL_LVL);
   localparam logic [4:0] AEMPTY_CNT = 5'(AEMPTY_LVL);

   logic [4:0] count_nxt;

   // Strobes use the registered flags so storage sees the current pointers.
   assign wr_ok = push & ~full  & ~flush;
   assign rd_ok = pop  & ~empty & ~flush;

   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else begin
         case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 5'd1;
            2'b01:   count_nxt = count - 5'd1;
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 4'd1;
            if (rd_ok) rd_ptr <= rd_ptr + 4'd1;
         end
         // Flags follow the next-state count so they change on the same edge.
         count        <= count_nxt;
         full         <= (count_nxt == DEPTH_CNT);
         empty        <= (count_nxt == 5'd0);
         almost_full  <= (count_nxt >= AFULL_CNT);
         almost_empty <= (count_nxt <= AEMPTY_CNT);
      end
   end

`ifdef FIFO_PTR_CTRL_ERR_EN
   // Sticky until reset; flush deliberately leaves them alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push & full  & ~flush) overflow  <= 1'b1;
         if (pop  & empty & ~flush) underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: a behavioural occupancy model queues the
// expected registered state each cycle, which is compared after the clock edge.
module tb_fifo_ptr_ctrl;

   localparam int AF = 14;
   localparam int AE = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       push  = 1'b0;
   logic       pop   = 1'b0;
   logic       flush = 1'b0;
   logic       wr_ok, rd_ok;
   logic [3:0] wr_ptr, rd_ptr;
   logic [4:0] count;
   logic       full, empty, almost_full, almost_empty;
`ifdef FIFO_PTR_CTRL_ERR_EN
   logic       overflow, underflow;
`endif

   fifo_ptr_ctrl #(.AFULL_LVL(AF), .AEMPTY_LVL(AE)) dut (
      .clock        (clock),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
      .flush        (flush),
      .wr_ok        (wr_ok),
      .rd_ok        (rd_ok),
      .wr_ptr       (wr_ptr),
      .rd_ptr       (rd_ptr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`ifdef FIFO_PTR_CTRL_ERR_EN
      ,
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      int wp;
      int rp;
      int cnt;
      bit f;
      bit e;
      bit af;
      bit ae;
      bit ov;
      bit un;
   } exp_t;

   exp_t sb[$];

   int m_wp, m_rp, m_cnt;
   bit m_ov, m_un, m_valid;
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input bit p, input bit q, input bit fl, input bit rs);
      exp_t e;
      bit   aw, ar;
      @(negedge clock);
      push  = p;
      pop   = q;
      flush = fl;
      reset = rs;
      #1;
      aw = p && (m_cnt < 16) && !fl;
      ar = q && (m_cnt > 0) && !fl;
      if (m_valid) begin
         check("wr_ok", 32'(wr_ok), 32'(aw));
         check("rd_ok", 32'(rd_ok), 32'(ar));
      end
      if (rs) begin
         m_wp = 0; m_rp = 0; m_cnt = 0; m_ov = 0; m_un = 0; m_valid = 1;
      end else if (fl) begin
         m_wp = 0; m_rp = 0; m_cnt = 0;
      end else begin
         if (p && m_cnt == 16) m_ov = 1;
         if (q && m_cnt == 0)  m_un = 1;
         if (aw) m_wp = (m_wp + 1) % 16;
         if (ar) m_rp = (m_rp + 1) % 16;
         m_cnt = m_cnt + (aw ? 1 : 0) - (ar ? 1 : 0);
      end
      e.wp  = m_wp;
      e.rp  = m_rp;
      e.cnt = m_cnt;
      e.f   = (m_cnt == 16);
      e.e   = (m_cnt == 0);
      e.af  = (m_cnt >= AF);
      e.ae  = (m_cnt <= AE);
      e.ov  = m_ov;
      e.un  = m_un;
      sb.push_back(e);
      @(posedge clock);
      #1;
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("wr_ptr",       32'(wr_ptr),       e.wp);
         check("rd_ptr",       32'(rd_ptr),       e.rp);
         check("count",        32'(count),        e.cnt);
         check("full",         32'(full),         32'(e.f));
         check("empty",        32'(empty),        32'(e.e));
         check("almost_full",  32'(almost_full),  32'(e.af));
         check("almost_empty", 32'(almost_empty), 32'(e.ae));
`ifdef FIFO_PTR_CTRL_ERR_EN
         check("overflow",     32'(overflow),     32'(e.ov));
         check("underflow",    32'(underflow),    32'(e.un));
`endif
      end
   endtask

   initial begin
      m_valid = 0;
      m_wp = 0; m_rp = 0; m_cnt = 0; m_ov = 0; m_un = 0;

      step(0, 0, 0, 1);                           // reset state
      for (int i = 0; i < 16; i++) step(1, 0, 0, 0); // fill, wr_ptr wraps to 0
      step(1, 0, 0, 0);                           // push while full: dropped, overflow
      step(1, 1, 0, 0);                           // push+pop while full: pop only
      step(0, 1, 0, 0);
      for (int i = 0; i < 14; i++) step(0, 1, 0, 0); // drain to empty
      step(0, 1, 0, 0);                           // pop while empty: dropped, underflow
      step(1, 1, 0, 0);                           // push+pop while empty: push only
      for (int i = 0; i < 7; i++) step(1, 0, 0, 0);  // count = 8
      step(1, 1, 0, 0);                           // both accepted, count holds

      step(0, 0, 1, 0);                           // flush
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0); // pointers wrap, count stays 3

      for (int i = 0; i < 6; i++) step(1, 0, 0, 0);  // count = 9
      step(1, 0, 1, 0);                           // flush beats push, sticky flags kept

      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);  // count = 5
      step(1, 1, 0, 1);                           // reset beats push/pop

      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0), ($urandom_range(0, 79) == 0));
      end
      for (int i = 0; i < 18; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 18; i++) step(0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
